ysyx_24080006_axi_arb: RTL and testbench
========================================

YSYX_24080006_AXI_ARB -- requirements
Module: ysyx_24080006_axi_arb

Interface
REQ-001 SHALL have parameter IFU_ID, default 4'd0: AXI ID driven on downstream arid for IFU reads.
REQ-002 SHALL have parameter LSU_ID, default 4'd1: AXI ID driven on downstream arid/awid for LSU transactions.
REQ-003 SHALL have port clock  input  1  core clock; single clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ifu  slave modport  ysyx_24080006_axi  instruction-fetch master, read-only.
REQ-006 SHALL have port lsu  slave modport  ysyx_24080006_axi  load/store master, read and write.
REQ-007 SHALL have port axi  master modport  ysyx_24080006_axi  merged core bus, feeds the CLINT crossbar.

Function
REQ-008 SHALL implement FSM states IDLE, RD_IFU, RD_LSU, WR_LSU, with at most one transaction outstanding in total.
REQ-009 SHALL, in IDLE, sample requests and register the grant, with downstream valids low during that cycle.
- Net latency: 1 cycle from upstream arvalid/awvalid to downstream valid.
REQ-010 SHALL, in RD_x, forward the granted master's AR channel to axi.
- Downstream arid forced to the matching *_ID parameter.
- Granted master's arready = axi.arready; the other master's arready held 0.
REQ-011 SHALL, in RD_x, route axi R channel (rdata, rresp, rlast, rvalid) to the granted master only.
- axi.rready = granted master's rready; the non-granted master sees rvalid=0.
REQ-012 SHALL support bursts (arlen up to 8'hFF), leaving RD_x only on rvalid&rready&rlast.
REQ-013 SHALL, in WR_LSU, forward LSU AW, W and B channels to axi, with awid forced to LSU_ID.
- AW and W handshakes tracked independently; each channel's valid deasserted downstream once it has been accepted.
REQ-014 SHALL leave WR_LSU only on bvalid&bready after both the AW and the last W (wlast) beat have completed, and SHALL then return to IDLE.
REQ-015 SHALL tie off the IFU write channels: awready=0, wready=0, bvalid=0.
REQ-016 SHALL, in IDLE, apply LSU-internal priority: LSU write before LSU read.
REQ-017 SHALL, in IDLE, resolve simultaneous IFU and LSU requests per REQ-023.
REQ-018 SHALL pass rresp/bresp unchanged; SLVERR/DECERR does not alter the FSM.
REQ-019 SHALL ignore axi.rid/axi.bid for routing; routing uses the registered grant only.
REQ-020 SHALL keep all upstream ready signals 0 in IDLE; no request is acknowledged before its grant.

Reset
REQ-021 SHALL, on reset (at any point, including mid-burst), return the FSM to IDLE and clear the grant and the AW/W-done flags.
REQ-022 SHALL, during and after reset, drive 0 on these outputs:
- downstream arvalid, awvalid, wvalid, rready, bready;
- all upstream arready, awready, wready, rvalid, bvalid.

Configuration
REQ-023 SHALL select the arbitration policy with macro YSYX_24080006_ARB_RR_EN.
- Defined: round-robin between IFU and LSU, using a 1-bit last-granted register (reset to IFU), updated when a transaction completes.
- Undefined: fixed priority, LSU over IFU, and no last-granted register.

Structure
REQ-024 SHALL place the FSM state enum (arb_state_t) and the default IFU_ID/LSU_ID constants in ysyx_24080006_pkg.
REQ-025 SHALL be a single module; the AW/W-done bookkeeping is inline, and no sub-module is required.

Verification
REQ-026 SHALL cover: IFU arvalid, araddr=32'h3000_0000, arlen=0 -> axi.arvalid one cycle later, arid=IFU_ID, ifu sees rdata; FSM back in IDLE the cycle after rlast.
REQ-027 SHALL cover: IFU and LSU assert arvalid in the same cycle, without the macro -> LSU is served first; IFU arready stays 0 until LSU rlast.
REQ-028 SHALL cover: the same as REQ-027 with YSYX_24080006_ARB_RR_EN, repeated 4 times -> grants alternate LSU, IFU, LSU, IFU (the first grant goes to LSU because last-granted resets to IFU).
REQ-029 SHALL cover: LSU write with addr 32'h8000_0010, wdata 32'hDEAD_BEEF, wstrb 4'hF; axi.wready delayed 3 cycles after awready -> single AW and W handshakes downstream, bresp relayed, exit only after bvalid.
REQ-030 SHALL cover: IFU burst with arlen=3 and reset asserted after beat 2 -> all valids 0 the next cycle, FSM IDLE, and a new IFU request is served normally.
REQ-031 SHALL cover: LSU read returning rresp=2'b10 -> the error is forwarded to lsu, and the FSM returns to IDLE normally.

Source files
------------

// File: rtl/ysyx_24080006_axi_arb_pkg.sv
// Shared types and constants for the IFU/LSU AXI arbiter.
package ysyx_24080006_pkg;

   // Default AXI IDs stamped on downstream requests
   localparam logic [3:0] IFU_ID_DEF = 4'd0;
   localparam logic [3:0] LSU_ID_DEF = 4'd1;

   // Encoding of the last-granted register (round-robin build only)
   localparam logic GNT_IFU = 1'b0;
   localparam logic GNT_LSU = 1'b1;

   // Arbiter FSM: the state itself is the registered grant
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_IFU = 2'd1,
      RD_LSU = 2'd2,
      WR_LSU = 2'd3
   } arb_state_t;

   // LSU-internal ordering: a pending write is always taken before a read
   function automatic arb_state_t lsu_grant_state(input logic awvalid);
      return awvalid ? WR_LSU : RD_LSU;
   endfunction

endpackage

// File: rtl/ysyx_24080006_axi_arb_if.sv
// AXI4 bus bundle (32-bit data, 4-bit ID) shared by IFU, LSU and the merged bus.
interface ysyx_24080006_axi;
   // AR
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   // R
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;
   // AW
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   // W
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   // B
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rdata, rresp, rlast, rid,
      output rready,
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp, bid,
      output bready
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      output arready,
      output rvalid, rdata, rresp, rlast, rid,
      input  rready,
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp, bid,
      input  bready
   );

endinterface

// File: rtl/ysyx_24080006_axi_arb.sv
// Two-master AXI arbiter: IFU (read-only) and LSU (read/write) merged onto
// one bus with a single transaction in flight. The grant is registered in
// IDLE, so a request reaches the bus one cycle after it is raised.
// Optional: YSYX_24080006_ARB_RR_EN selects IFU/LSU round-robin; without it
// the LSU has fixed priority over the IFU.
module ysyx_24080006_axi_arb
   import ysyx_24080006_pkg::*;
#(
   parameter logic [3:0] IFU_ID = IFU_ID_DEF,
   parameter logic [3:0] LSU_ID = LSU_ID_DEF
) (
   input  logic             clock,
   input  logic             reset,
   ysyx_24080006_axi.slave  ifu,
   ysyx_24080006_axi.slave  lsu,
   ysyx_24080006_axi.master axi
);

   arb_state_t state_q, state_d;
   // ardone keeps a second AR from a master from slipping out mid-burst
   logic       ardone_q, ardone_d;
   logic       awdone_q, awdone_d;
   logic       wdone_q,  wdone_d;
`ifdef YSYX_24080006_ARB_RR_EN
   logic       last_q,   last_d;
`endif

   logic rd_ifu, rd_lsu, wr_lsu;
   logic ifu_req, lsu_req, gnt_lsu;
   logic ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;

   // State decode; reset forces every channel quiet within the reset cycle
   assign rd_ifu = (state_q == RD_IFU) & ~reset;
   assign rd_lsu = (state_q == RD_LSU) & ~reset;
   assign wr_lsu = (state_q == WR_LSU) & ~reset;

   assign ifu_req = ifu.arvalid;
   assign lsu_req = lsu.awvalid | lsu.arvalid;

`ifdef YSYX_24080006_ARB_RR_EN
   // Round-robin: on contention, serve whoever was not served last
   assign gnt_lsu = lsu_req & (~ifu_req | (last_q == GNT_IFU));
`else
   // Fixed priority: LSU always wins
   assign gnt_lsu = lsu_req;
`endif

   assign ar_hs     = axi.arvalid & axi.arready;
   assign r_last_hs = axi.rvalid & axi.rready & axi.rlast;
   assign aw_hs     = axi.awvalid & axi.awready;
   assign w_last_hs = axi.wvalid & axi.wready & axi.wlast;
   assign b_hs      = axi.bvalid & axi.bready;

   // Downstream request/response-ready muxing driven from the registered grant
   always_comb begin
      axi.arvalid = 1'b0;
      axi.araddr  = '0;
      axi.arid    = IFU_ID;
      axi.arlen   = '0;
      axi.arsize  = '0;
      axi.arburst = '0;
      axi.rready  = 1'b0;
      axi.awvalid = 1'b0;
      axi.awaddr  = '0;
      axi.awid    = LSU_ID;
      axi.awlen   = '0;
      axi.awsize  = '0;
      axi.awburst = '0;
      axi.wvalid  = 1'b0;
      axi.wdata   = '0;
      axi.wstrb   = '0;
      axi.wlast   = 1'b0;
      axi.bready  = 1'b0;
      if (rd_ifu) begin
         axi.arvalid = ifu.arvalid & ~ardone_q;
         axi.araddr  = ifu.araddr;
         axi.arid    = IFU_ID;
         axi.arlen   = ifu.arlen;
         axi.arsize  = ifu.arsize;
         axi.arburst = ifu.arburst;
         axi.rready  = ifu.rready;
      end else if (rd_lsu) begin
         axi.arvalid = lsu.arvalid & ~ardone_q;
         axi.araddr  = lsu.araddr;
         axi.arid    = LSU_ID;
         axi.arlen   = lsu.arlen;
         axi.arsize  = lsu.arsize;
         axi.arburst = lsu.arburst;
         axi.rready  = lsu.rready;
      end else if (wr_lsu) begin
         // AW and W retire independently; each valid drops once accepted
         axi.awvalid = lsu.awvalid & ~awdone_q;
         axi.awaddr  = lsu.awaddr;
         axi.awlen   = lsu.awlen;
         axi.awsize  = lsu.awsize;
         axi.awburst = lsu.awburst;
         axi.wvalid  = lsu.wvalid & ~wdone_q;
         axi.wdata   = lsu.wdata;
         axi.wstrb   = lsu.wstrb;
         axi.wlast   = lsu.wlast;
         // B is only taken once the whole request has been handed over
         axi.bready  = lsu.bready & awdone_q & wdone_q;
      end
   end

   // IFU side: read channels follow the grant, write channels are tied off
   assign ifu.arready = rd_ifu & axi.arready & ~ardone_q;
   assign ifu.rvalid  = rd_ifu & axi.rvalid;
   assign ifu.rdata   = axi.rdata;
   assign ifu.rresp   = axi.rresp;
   assign ifu.rlast   = axi.rlast;
   assign ifu.rid     = axi.rid;
   assign ifu.awready = 1'b0;
   assign ifu.wready  = 1'b0;
   assign ifu.bvalid  = 1'b0;
   assign ifu.bresp   = 2'b00;
   assign ifu.bid     = '0;

   // LSU side: responses pass through untouched, gated only by the grant
   assign lsu.arready = rd_lsu & axi.arready & ~ardone_q;
   assign lsu.rvalid  = rd_lsu & axi.rvalid;
   assign lsu.rdata   = axi.rdata;
   assign lsu.rresp   = axi.rresp;
   assign lsu.rlast   = axi.rlast;
   assign lsu.rid     = axi.rid;
   assign lsu.awready = wr_lsu & axi.awready & ~awdone_q;
   assign lsu.wready  = wr_lsu & axi.wready & ~wdone_q;
   assign lsu.bvalid  = wr_lsu & axi.bvalid & awdone_q & wdone_q;
   assign lsu.bresp   = axi.bresp;
   assign lsu.bid     = axi.bid;

   // Next-state: grant in IDLE, retire on last R beat or on B
   always_comb begin
      state_d  = state_q;
      ardone_d = ardone_q;
      awdone_d = awdone_q;
      wdone_d  = wdone_q;
`ifdef YSYX_24080006_ARB_RR_EN
      last_d   = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt_lsu)      state_d = lsu_grant_state(lsu.awvalid);
            else if (ifu_req) state_d = RD_IFU;
         end
         RD_IFU, RD_LSU: begin
            if (ar_hs) ardone_d = 1'b1;
            if (r_last_hs) begin
               state_d  = IDLE;
               ardone_d = 1'b0;
`ifdef YSYX_24080006_ARB_RR_EN
               last_d   = (state_q == RD_LSU) ? GNT_LSU : GNT_IFU;
`endif
            end
         end
         WR_LSU: begin
            if (aw_hs)     awdone_d = 1'b1;
            if (w_last_hs) wdone_d  = 1'b1;
            if (b_hs) begin
               state_d  = IDLE;
               awdone_d = 1'b0;
               wdone_d  = 1'b0;
`ifdef YSYX_24080006_ARB_RR_EN
               last_d   = GNT_LSU;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and bookkeeping registers, synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         ardone_q <= 1'b0;
         awdone_q <= 1'b0;
         wdone_q  <= 1'b0;
`ifdef YSYX_24080006_ARB_RR_EN
         last_q   <= GNT_IFU;
`endif
      end else begin
         state_q  <= state_d;
         ardone_q <= ardone_d;
         awdone_q <= awdone_d;
         wdone_q  <= wdone_d;
`ifdef YSYX_24080006_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_ysyx_24080006_axi_arb.sv
// Directed + randomized bench for the IFU/LSU AXI arbiter. The bench plays
// both upstream masters and the downstream slave; the expected grant order
// comes from a small policy model (last-granted master, LSU write first).
module tb_ysyx_24080006_axi_arb;
   import ysyx_24080006_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   ysyx_24080006_axi ifu_b ();
   ysyx_24080006_axi lsu_b ();
   ysyx_24080006_axi axi_b ();

   ysyx_24080006_axi_arb dut (
      .clock (clock),
      .reset (reset),
      .ifu   (ifu_b),
      .lsu   (lsu_b),
      .axi   (axi_b)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   bit          last_m;          // model: last served master, 0=IFU 1=LSU
   logic [31:0] req_addr [2];
   logic [7:0]  req_len  [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Policy model: only requester wins; on contention fixed LSU or alternate
   function automatic bit pick(input bit ifu_r, input bit lsu_r);
      if (!lsu_r) return 1'b0;
      if (!ifu_r) return 1'b1;
`ifdef YSYX_24080006_ARB_RR_EN
      return (last_m == 1'b0);
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic m_arready(input bit m);
      return m ? lsu_b.arready : ifu_b.arready;
   endfunction
   function automatic logic m_rvalid(input bit m);
      return m ? lsu_b.rvalid : ifu_b.rvalid;
   endfunction
   function automatic logic [31:0] m_rdata(input bit m);
      return m ? lsu_b.rdata : ifu_b.rdata;
   endfunction
   function automatic logic [1:0] m_rresp(input bit m);
      return m ? lsu_b.rresp : ifu_b.rresp;
   endfunction
   function automatic logic m_rlast(input bit m);
      return m ? lsu_b.rlast : ifu_b.rlast;
   endfunction

   task automatic set_ar(input bit m, input logic v, input logic [31:0] a, input logic [7:0] l);
      if (m) begin lsu_b.arvalid = v; lsu_b.araddr = a; lsu_b.arlen = l; end
      else   begin ifu_b.arvalid = v; ifu_b.araddr = a; ifu_b.arlen = l; end
   endtask

   task automatic set_rready(input bit m, input logic v);
      if (m) lsu_b.rready = v; else ifu_b.rready = v;
   endtask

   task automatic req(input bit m, input logic [31:0] a, input logic [7:0] l);
      req_addr[m] = a;
      req_len[m]  = l;
      set_ar(m, 1'b1, a, l);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_dn"},  64'({axi_b.arvalid, axi_b.awvalid, axi_b.wvalid, axi_b.rready, axi_b.bready}), 0);
      chk({tag, "_ifu"}, 64'({ifu_b.arready, ifu_b.awready, ifu_b.wready, ifu_b.rvalid, ifu_b.bvalid}), 0);
      chk({tag, "_lsu"}, 64'({lsu_b.arready, lsu_b.awready, lsu_b.wready, lsu_b.rvalid, lsu_b.bvalid}), 0);
   endtask

   // Serve a read already raised by master m; entered just after a clock edge
   // with the arbiter idle. abort_at >= 0 asserts reset after that many beats.
   task automatic serve(input bit m, input logic [1:0] resp, input int abort_at);
      logic [3:0]  id;
      logic [31:0] d;
      logic        rl, rr;
      int          nd;
      id = m ? 4'd1 : 4'd0;
      @(negedge clock);
      chk("idle_state", 64'(dut.state_q), 64'(IDLE));
      chk("idle_ar", 64'({axi_b.arvalid, ifu_b.arready, lsu_b.arready}), 0);
      tick();
      nd = $urandom_range(0, 2);
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         chk("ar_valid", 64'(axi_b.arvalid), 1);
         chk("ar_id", 64'(axi_b.arid), 64'(id));
         chk("ar_addr", 64'(axi_b.araddr), 64'(req_addr[m]));
         chk("ar_len", 64'(axi_b.arlen), 64'(req_len[m]));
         chk("ar_rdy_gnt", 64'(m_arready(m)), 64'(axi_b.arready));
         chk("ar_rdy_oth", 64'(m_arready(!m)), 0);
         if (axi_b.arready) break;
         tick();
         if (k >= nd) axi_b.arready = 1'b1;
      end
      tick();
      set_ar(m, 1'b0, 32'h0, 8'h0);
      axi_b.arready = 1'b0;
      for (int b = 0; b <= int'(req_len[m]); b++) begin
         if (b == abort_at) begin
            reset = 1'b1;
            axi_b.rvalid = 1'b1;
            set_rready(m, 1'b1);
            set_ar(m, 1'b1, req_addr[m], req_len[m]);
            @(negedge clock);
            chk_quiet("rst_during");
            tick();
            reset = 1'b0;
            axi_b.rvalid = 1'b0;
            set_rready(m, 1'b0);
            set_ar(m, 1'b0, 32'h0, 8'h0);
            @(negedge clock);
            chk_quiet("rst_after");
            chk("rst_state", 64'(dut.state_q), 64'(IDLE));
            tick();
            last_m = 1'b0;
            return;
         end
         repeat ($urandom_range(0, 1)) begin
            @(negedge clock);
            chk("r_gap", 64'({m_rvalid(1'b0), m_rvalid(1'b1)}), 0);
            tick();
         end
         d  = $urandom;
         rl = (b == int'(req_len[m]));
         rr = 1'($urandom_range(0, 1));
         axi_b.rvalid = 1'b1;
         axi_b.rdata  = d;
         axi_b.rresp  = resp;
         axi_b.rlast  = rl;
         axi_b.rid    = 4'($urandom);
         set_rready(m, rr);
         for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("r_valid", 64'(m_rvalid(m)), 1);
            chk("r_data", 64'(m_rdata(m)), 64'(d));
            chk("r_resp", 64'(m_rresp(m)), 64'(resp));
            chk("r_last", 64'(m_rlast(m)), 64'(rl));
            chk("r_oth", 64'(m_rvalid(!m)), 0);
            chk("r_rready", 64'(axi_b.rready), 64'(rr));
            chk("r_ar_oth", 64'(m_arready(!m)), 0);
            if (rr) break;
            tick();
            rr = (k >= 1) ? 1'b1 : 1'($urandom_range(0, 1));
            set_rready(m, rr);
         end
         tick();
         axi_b.rvalid = 1'b0;
         axi_b.rlast  = 1'b0;
         set_rready(m, 1'b0);
      end
      last_m = m;
   endtask

   // Single-beat LSU write; downstream wready comes 3 cycles after awready.
   task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] br, input bit also_rd);
      int aw_at, aw_on, aw_hs, w_hs;
      bit awd, wd, awf, wf, done;
      aw_at = $urandom_range(0, 1);
      aw_on = -1; aw_hs = 0; w_hs = 0;
      awd = 0; wd = 0; done = 0;
      lsu_b.awvalid = 1'b1; lsu_b.awaddr = a; lsu_b.awlen = 8'h0;
      lsu_b.wvalid  = 1'b1; lsu_b.wdata  = d; lsu_b.wstrb = s; lsu_b.wlast = 1'b1;
      lsu_b.bready  = 1'b1;
      if (also_rd) req(1'b1, $urandom, 8'(($urandom_range(0, 2))));
      @(negedge clock);
      chk("wr_idle", 64'(dut.state_q), 64'(IDLE));
      chk("wr_idle_q", 64'({axi_b.awvalid, axi_b.wvalid, lsu_b.awready, lsu_b.wready, lsu_b.arready}), 0);
      tick();
      if (aw_at == 0) begin axi_b.awready = 1'b1; aw_on = 0; end
      for (int c = 0; c < 24; c++) begin
         @(negedge clock);
         chk("wr_state", 64'(dut.state_q), 64'(WR_LSU));
         chk("wr_no_ar", 64'({axi_b.arvalid, ifu_b.arready, lsu_b.arready}), 0);
         chk("aw_valid", 64'(axi_b.awvalid), 64'(!awd));
         chk("w_valid", 64'(axi_b.wvalid), 64'(!wd));
         chk("aw_rdy_up", 64'(lsu_b.awready), 64'(axi_b.awready & !awd));
         chk("w_rdy_up", 64'(lsu_b.wready), 64'(axi_b.wready & !wd));
         chk("b_rdy_dn", 64'(axi_b.bready), 64'(awd & wd));
         chk("b_valid_up", 64'(lsu_b.bvalid), 64'(axi_b.bvalid));
         if (axi_b.awvalid) begin
            chk("aw_id", 64'(axi_b.awid), 64'(4'd1));
            chk("aw_addr", 64'(axi_b.awaddr), 64'(a));
         end
         if (axi_b.wvalid) chk("w_data", 64'({axi_b.wdata, axi_b.wstrb, axi_b.wlast}), 64'({d, s, 1'b1}));
         if (axi_b.awvalid && axi_b.awready) aw_hs++;
         if (axi_b.wvalid && axi_b.wready) w_hs++;
         awf = lsu_b.awvalid && lsu_b.awready;
         wf  = lsu_b.wvalid && lsu_b.wready;
         if (axi_b.bvalid && lsu_b.bvalid) begin
            chk("b_resp", 64'(lsu_b.bresp), 64'(br));
            done = 1;
         end
         tick();
         if (done) break;
         if (awf) begin awd = 1; lsu_b.awvalid = 1'b0; end
         if (wf)  begin wd = 1; lsu_b.wvalid = 1'b0; end
         if (!axi_b.awready && c + 1 >= aw_at) begin axi_b.awready = 1'b1; aw_on = c + 1; end
         if (aw_on >= 0 && c + 1 >= aw_on + 3) axi_b.wready = 1'b1;
         if (awd && wd) begin axi_b.bvalid = 1'b1; axi_b.bresp = br; end
      end
      axi_b.bvalid = 1'b0; axi_b.awready = 1'b0; axi_b.wready = 1'b0;
      lsu_b.bready = 1'b0; lsu_b.awvalid = 1'b0; lsu_b.wvalid = 1'b0;
      chk("wr_done", 64'(done), 1);
      chk("aw_count", 64'(aw_hs), 1);
      chk("w_count", 64'(w_hs), 1);
      last_m = 1'b1;
   endtask

   task automatic contend();
      bit w;
      req(1'b0, $urandom, 8'(($urandom_range(0, 2))));
      req(1'b1, $urandom, 8'(($urandom_range(0, 2))));
      w = pick(1'b1, 1'b1);
      serve(w, 2'b00, -1);
      serve(!w, 2'b00, -1);
   endtask

   initial begin
      bit m;
      last_m = 1'b0;
      reset  = 1'b1;
      // Every handshake input active during reset: outputs must still be quiet
      ifu_b.arvalid = 1'b1; ifu_b.araddr = '0; ifu_b.arlen = '0; ifu_b.arid = '0;
      ifu_b.arsize = 3'd2;  ifu_b.arburst = 2'b01; ifu_b.rready = 1'b1;
      ifu_b.awvalid = 1'b0; ifu_b.awaddr = '0; ifu_b.awid = '0; ifu_b.awlen = '0;
      ifu_b.awsize = '0; ifu_b.awburst = '0; ifu_b.wvalid = 1'b0; ifu_b.wdata = '0;
      ifu_b.wstrb = '0; ifu_b.wlast = 1'b0; ifu_b.bready = 1'b0;
      lsu_b.arvalid = 1'b1; lsu_b.araddr = '0; lsu_b.arlen = '0; lsu_b.arid = '0;
      lsu_b.arsize = 3'd2;  lsu_b.arburst = 2'b01; lsu_b.rready = 1'b1;
      lsu_b.awvalid = 1'b1; lsu_b.awaddr = '0; lsu_b.awid = '0; lsu_b.awlen = '0;
      lsu_b.awsize = 3'd2;  lsu_b.awburst = 2'b01; lsu_b.wvalid = 1'b1; lsu_b.wdata = '0;
      lsu_b.wstrb = '0; lsu_b.wlast = 1'b1; lsu_b.bready = 1'b1;
      axi_b.arready = 1'b1; axi_b.rvalid = 1'b1; axi_b.rdata = '0; axi_b.rresp = '0;
      axi_b.rlast = 1'b1; axi_b.rid = '0; axi_b.awready = 1'b1; axi_b.wready = 1'b1;
      axi_b.bvalid = 1'b1; axi_b.bresp = '0; axi_b.bid = '0;
      @(negedge clock);
      chk_quiet("rst_hold");
      tick();
      @(negedge clock);
      chk_quiet("rst_hold2");
      tick();
      reset = 1'b0;
      ifu_b.arvalid = 1'b0; ifu_b.rready = 1'b0;
      lsu_b.arvalid = 1'b0; lsu_b.rready = 1'b0; lsu_b.awvalid = 1'b0;
      lsu_b.wvalid = 1'b0; lsu_b.bready = 1'b0; lsu_b.wlast = 1'b0;
      axi_b.arready = 1'b0; axi_b.rvalid = 1'b0; axi_b.rlast = 1'b0;
      axi_b.awready = 1'b0; axi_b.wready = 1'b0; axi_b.bvalid = 1'b0;
      @(negedge clock);
      chk_quiet("post_rst");
      chk("post_rst_state", 64'(dut.state_q), 64'(IDLE));
      tick();

      // Single IFU fetch, then confirm the arbiter is idle right after rlast
      req(1'b0, 32'h3000_0000, 8'h0);
      serve(1'b0, 2'b00, -1);
      @(negedge clock);
      chk("ifu_done_state", 64'(dut.state_q), 64'(IDLE));
      chk_quiet("ifu_done");
      tick();

      // LSU read answered with SLVERR
      req(1'b1, $urandom, 8'(($urandom_range(0, 2))));
      serve(1'b1, 2'b10, -1);

      // Simultaneous IFU/LSU reads, four rounds
      repeat (4) contend();

      // LSU write with a pending LSU read behind it, then an erroring write
      wr_txn(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 1'b1);
      serve(1'b1, 2'b00, -1);
      wr_txn($urandom, $urandom, 4'($urandom), 2'b10, 1'b0);

      // Contention right after an LSU transaction: policy decides the order
      contend();

      // Random single-master reads
      repeat (6) begin
         m = 1'($urandom_range(0, 1));
         req(m, $urandom, 8'(($urandom_range(0, 4))));
         serve(pick(!m, m), 2'($urandom_range(0, 3)), -1);
      end

      // IFU burst interrupted by reset after two beats, then a clean fetch
      req(1'b0, $urandom, 8'd3);
      serve(1'b0, 2'b00, 2);
      req(1'b0, $urandom, 8'(($urandom_range(0, 3))));
      serve(1'b0, 2'b00, -1);
      @(negedge clock);
      chk_quiet("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
